// File: rtl/fetch_queue_pc_pkg.sv
// Shared types for the fetch front end: bus request/response, exception causes
// and the prefetch queue entry.
package fetch_queue_pc_pkg;

  localparam int MAX_PC_W = 64;

  typedef enum logic [4:0] {
    INSTRUCTION_ADDRESS_MISALIGNED = 5'd0,
    INSTRUCTION_ACCESS_FAULT       = 5'd1,
    ILLEGAL_INSTRUCTION            = 5'd2,
    INT_SOFTWARE                   = 5'd3,
    INT_TIMER                      = 5'd7,
    INT_EXTERNAL                   = 5'd11
  } exception_t;

  typedef struct packed {
    logic [MAX_PC_W-1:0] addr;
    logic                valid;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic [MAX_PC_W-1:0] pc;
    logic [31:0]         instr;
    logic                exc_valid;
    exception_t          exc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2,
    HALT    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue_pc_if.sv
// Fetch front-end signal bundle: instruction bus, redirect/interrupt inputs
// and the valid/ready port towards decode.
interface fetch_queue_pc_if #(
  parameter int PC_W = 64
);
  fetch_queue_pc_pkg::ibus_req_t  ibus_req;
  fetch_queue_pc_pkg::ibus_resp_t ibus_resp;
  logic                           redirect_valid;
  logic [PC_W-1:0]                redirect_pc;
  logic                           int_pending;
  fetch_queue_pc_pkg::exception_t int_cause;
  logic                           out_valid;
  logic                           out_ready;
  logic [PC_W-1:0]                out_pc;
  logic [31:0]                    out_instr;
  logic                           out_exc_valid;
  fetch_queue_pc_pkg::exception_t out_exc;

  modport master (
    output ibus_req, out_valid, out_pc, out_instr, out_exc_valid, out_exc,
    input  ibus_resp, redirect_valid, redirect_pc, int_pending, int_cause, out_ready
  );

  modport slave (
    input  ibus_req, out_valid, out_pc, out_instr, out_exc_valid, out_exc,
    output ibus_resp, redirect_valid, redirect_pc, int_pending, int_cause, out_ready
  );
endinterface

// File: rtl/fetch_queue_pc_fetch_fifo.sv
// Prefetch queue: power-of-two ring buffer with registered head.
// Flush beats push; push into a full queue is accepted only alongside a pop.
module fetch_fifo
  import fetch_queue_pc_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 push_data,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue_pc.sv
// Fetch front end: PC generator issuing one instruction-bus request at a time
// into a prefetch queue, with redirect, misaligned-target and interrupt handling.
//
// state   | meaning
// IDLE    | ready to issue at fetch_pc, or raise a misaligned exception
// REQ     | request outstanding, reply will be queued
// DISCARD | request outstanding, reply will be dropped (after redirect/interrupt)
// HALT    | no fetching until a redirect
module fetch_queue_pc
  import fetch_queue_pc_pkg::*;
#(
  parameter int          PC_W   = 64,
  parameter int          DEPTH  = 4,
  parameter logic [63:0] PCINIT = 64'h8000_0000
) (
  input logic              clk,
  input logic              rst,
  fetch_queue_pc_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state, state_nxt;
  logic [PC_W-1:0]  fetch_pc, req_addr, int_pc;
  logic             to_halt, int_valid;
  exception_t       int_exc;
  logic             req_active, handshake, misaligned, has_slot;
  logic             flush, push, pop, issue;
  fetch_entry_t     push_entry, head;
  logic [CNT_W-1:0] count;
  logic             empty, full;

  assign req_active = (state == REQ) || (state == DISCARD);
  assign handshake  = req_active && bus.ibus_resp.addr_ok && bus.ibus_resp.data_ok;
  assign misaligned = |fetch_pc[1:0];
  assign has_slot   = count < CNT_W'(DEPTH);
  assign flush      = bus.redirect_valid || bus.int_pending;
  assign pop        = bus.out_ready && !int_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.redirect_valid) begin
      state_nxt = (req_active && !handshake) ? DISCARD : IDLE;
    end else if (bus.int_pending) begin
      state_nxt = (req_active && !handshake) ? DISCARD : HALT;
    end else begin
      case (state)
        IDLE: begin
          if (misaligned && !full)         state_nxt = HALT;
          else if (!misaligned && has_slot) state_nxt = REQ;
        end
        REQ:     if (handshake) state_nxt = IDLE;
        DISCARD: if (handshake) state_nxt = to_halt ? HALT : IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    push       = 1'b0;
    issue      = 1'b0;
    push_entry = '{pc: MAX_PC_W'(fetch_pc), instr: bus.ibus_resp.data,
                   exc_valid: 1'b0, exc: INSTRUCTION_ADDRESS_MISALIGNED};
    if (!flush) begin
      case (state)
        IDLE: begin
          if (misaligned) begin
            if (!full) begin
              push                 = 1'b1;
              push_entry.instr     = '0;
              push_entry.exc_valid = 1'b1;
            end
          end else if (has_slot) begin
            issue = 1'b1;
          end
        end
        REQ:     push = handshake;
        default: push = 1'b0;
      endcase
    end
  end

  // req_addr freezes the outstanding address so a redirect cannot disturb it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= PCINIT[PC_W-1:0];
      req_addr <= PCINIT[PC_W-1:0];
      to_halt  <= 1'b0;
    end else begin
      if (bus.redirect_valid)                fetch_pc <= bus.redirect_pc;
      else if (push && !push_entry.exc_valid) fetch_pc <= fetch_pc + PC_W'(4);
      if (issue) req_addr <= fetch_pc;
      if (bus.redirect_valid)   to_halt <= 1'b0;
      else if (bus.int_pending) to_halt <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_valid <= 1'b0;
      int_pc    <= PCINIT[PC_W-1:0];
      int_exc   <= INSTRUCTION_ADDRESS_MISALIGNED;
    end else if (bus.redirect_valid) begin
      int_valid <= 1'b0;
    end else if (bus.int_pending) begin
      int_valid <= 1'b1;
      int_pc    <= empty ? fetch_pc : head.pc[PC_W-1:0];
      int_exc   <= bus.int_cause;
    end else if (bus.out_ready) begin
      int_valid <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_entry),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign bus.ibus_req      = '{addr: MAX_PC_W'(req_addr), valid: req_active};
  assign bus.out_valid     = int_valid || !empty;
  assign bus.out_pc        = int_valid ? int_pc : head.pc[PC_W-1:0];
  assign bus.out_instr     = int_valid ? 32'd0 : head.instr;
  assign bus.out_exc_valid = int_valid || (!empty && head.exc_valid);
  assign bus.out_exc       = int_valid ? int_exc : head.exc;

endmodule

// File: tb/tb_fetch_queue_pc.sv
// Bench for fetch_queue_pc: bus responder plus an expected-entry queue that
// follows the fetch stream, redirects, misaligned targets and interrupts.
`timescale 1ns/1ps
module tb_fetch_queue_pc;
  import fetch_queue_pc_pkg::*;

  localparam int          PC_W   = 64;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] PCINIT = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_pc_if #(.PC_W(PC_W)) ifc ();
  fetch_queue_pc #(.PC_W(PC_W), .DEPTH(DEPTH), .PCINIT(PCINIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    bit          exc_valid;
    exception_t  exc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] popped[$];
  logic [63:0] req_addrs[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] next_req_pc;
  bit          no_fetch, mis_pending;
  bit          bus_pend, bus_stale, prev_hs, lat_rand;
  logic [63:0] bus_addr;
  int          bus_wait, lat, n_hs, n_pop;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[17:2]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive_idle();
    ifc.ibus_resp      = '{addr_ok: 1'b0, data_ok: 1'b0, data: 32'd0};
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.int_pending    = 1'b0;
    ifc.int_cause      = INT_SOFTWARE;
    ifc.out_ready      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    exp_q.delete(); popped.delete(); req_addrs.delete();
    next_req_pc = PCINIT; no_fetch = 0; mis_pending = 0;
    bus_pend = 0; bus_stale = 0; prev_hs = 0; n_hs = 0; n_pop = 0;
    @(negedge clk);
    chk("rst_req_valid", 64'(ifc.ibus_req.valid), 64'd0);
    chk("rst_req_addr", ifc.ibus_req.addr, PCINIT);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_out_exc_valid", 64'(ifc.out_exc_valid), 64'd0);
    rst = 1'b1;
  endtask

  task automatic step(input bit rdy, input bit redir, input logic [63:0] tgt,
                      input bit intr, input exception_t cause);
    bit   hs_now;
    exp_t e;
    @(negedge clk);
    hs_now = 0;
    if (prev_hs) chk("req_valid_drop", 64'(ifc.ibus_req.valid), 64'd0);
    prev_hs = 0;
    if (bus_pend) begin
      chk("req_valid_hold", 64'(ifc.ibus_req.valid), 64'd1);
      chk("req_addr_hold", ifc.ibus_req.addr, bus_addr);
    end else begin
      if (no_fetch) chk("halted_req_valid", 64'(ifc.ibus_req.valid), 64'd0);
      if (ifc.ibus_req.valid) begin
        if (!no_fetch) chk("req_addr", ifc.ibus_req.addr, next_req_pc);
        bus_pend  = 1;
        bus_addr  = ifc.ibus_req.addr;
        bus_wait  = lat_rand ? int'($urandom_range(0, 3)) : lat;
        bus_stale = no_fetch;
        req_addrs.push_back(ifc.ibus_req.addr);
      end
    end
    if (bus_pend && bus_wait == 0) begin
      ifc.ibus_resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: word_at(bus_addr)};
      hs_now = 1;
    end else begin
      ifc.ibus_resp = '{addr_ok: 1'($urandom_range(0, 1)), data_ok: 1'b0, data: $urandom};
      if (bus_pend) bus_wait--;
    end
    if (!mis_pending) chk("out_valid", 64'(ifc.out_valid), 64'(exp_q.size() != 0));
    ifc.out_ready      = rdy;
    ifc.redirect_valid = redir;
    ifc.redirect_pc    = tgt;
    ifc.int_pending    = intr;
    ifc.int_cause      = cause;
    if (redir) begin
      exp_q.delete();
      if (bus_pend) bus_stale = 1;
      next_req_pc = tgt; no_fetch = 0; mis_pending = 0;
      if (tgt[1:0] != 2'b00) begin
        exp_q.push_back('{pc: tgt, instr: 32'd0, exc_valid: 1'b1,
                          exc: INSTRUCTION_ADDRESS_MISALIGNED});
        mis_pending = 1; no_fetch = 1;
      end
    end else if (intr) begin
      e.pc = (exp_q.size() != 0) ? exp_q[0].pc : next_req_pc;
      e.instr = 32'd0; e.exc_valid = 1'b1; e.exc = cause;
      exp_q.delete();
      exp_q.push_back(e);
      if (bus_pend) bus_stale = 1;
      no_fetch = 1; mis_pending = 0;
    end else if (ifc.out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(ifc.out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", ifc.out_pc, e.pc);
        chk("out_instr", 64'(ifc.out_instr), 64'(e.instr));
        chk("out_exc_valid", 64'(ifc.out_exc_valid), 64'(e.exc_valid));
        if (e.exc_valid) begin
          chk("out_exc", 64'(ifc.out_exc), 64'(e.exc));
          mis_pending = 0;
        end
        popped.push_back(ifc.out_pc);
        n_pop++;
      end
    end
    if (hs_now) begin
      bus_pend = 0; prev_hs = 1; n_hs++;
      if (!bus_stale && !redir && !intr) begin
        exp_q.push_back('{pc: bus_addr, instr: word_at(bus_addr), exc_valid: 1'b0,
                          exc: INSTRUCTION_ADDRESS_MISALIGNED});
        next_req_pc += 64'd4;
      end
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(rdy, 1'b0, '0, 1'b0, INT_SOFTWARE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          redir, intr;
    logic [63:0] tgt;
    drive_idle();
    lat = 0; lat_rand = 0;

    // sequential fetch, 1-cycle bus, decode always ready
    do_reset();
    run(12, 1'b1);
    chk("A_pop_count_ge3", 64'(popped.size() >= 3), 64'd1);
    if (popped.size() >= 3) begin
      chk("A_pc0", popped[0], 64'h8000_0000);
      chk("A_pc1", popped[1], 64'h8000_0004);
      chk("A_pc2", popped[2], 64'h8000_0008);
    end

    // decode stalled: queue fills, then drains and fetch resumes
    do_reset();
    run(20, 1'b0);
    chk("B_handshakes", 64'(n_hs), 64'd4);
    chk("B_req_idle_when_full", 64'(ifc.ibus_req.valid), 64'd0);
    for (int i = 0; i < 20 && n_pop < 4; i++) run(1, 1'b1);
    chk("B_drained", 64'(n_pop), 64'd4);
    run(6, 1'b1);
    chk("B_resume_seen", 64'(req_addrs.size() >= 5), 64'd1);
    if (req_addrs.size() >= 5) chk("B_resume_addr", req_addrs[4], 64'h8000_0010);

    // redirect while a slow request is in flight
    do_reset();
    lat = 3;
    for (int i = 0; i < 5 && !bus_pend; i++) run(1, 1'b1);
    chk("C_req_pending", 64'(bus_pend), 64'd1);
    step(1'b1, 1'b1, 64'h8000_0100, 1'b0, INT_SOFTWARE);
    popped.delete();
    run(25, 1'b1);
    chk("C_req_after_redirect", (req_addrs.size() >= 2) ? req_addrs[1] : 64'hX, 64'h8000_0100);
    chk("C_first_pop", (popped.size() >= 1) ? popped[0] : 64'hX, 64'h8000_0100);

    // misaligned redirect target
    step(1'b1, 1'b1, 64'h8000_0102, 1'b0, INT_SOFTWARE);
    popped.delete();
    run(20, 1'b1);
    chk("D_pop_count", 64'(popped.size()), 64'd1);
    chk("D_pop_pc", (popped.size() >= 1) ? popped[0] : 64'hX, 64'h8000_0102);

    // interrupt with two entries queued
    lat = 0;
    step(1'b0, 1'b1, 64'h8000_0020, 1'b0, INT_SOFTWARE);
    for (int i = 0; i < 20 && exp_q.size() < 2; i++) run(1, 1'b0);
    chk("E_two_queued", 64'(ifc.out_valid), 64'd1);
    step(1'b0, 1'b0, '0, 1'b1, INT_TIMER);
    popped.delete();
    run(12, 1'b1);
    chk("E_pop_count", 64'(popped.size()), 64'd1);
    chk("E_pop_pc", (popped.size() >= 1) ? popped[0] : 64'hX, 64'h8000_0020);

    // redirect and interrupt together: redirect wins
    step(1'b1, 1'b1, 64'h8000_0200, 1'b1, INT_EXTERNAL);
    popped.delete();
    run(10, 1'b1);
    chk("F_first_pop", (popped.size() >= 1) ? popped[0] : 64'hX, 64'h8000_0200);

    // reset asserted with a request outstanding
    lat = 3;
    for (int i = 0; i < 10 && !bus_pend; i++) run(1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("G_async_valid_drop", 64'(ifc.ibus_req.valid), 64'd0);
    chk("G_async_out_valid", 64'(ifc.out_valid), 64'd0);
    do_reset();

    // randomized traffic
    lat_rand = 1;
    n_pop = 0;
    for (int i = 0; i < 1500; i++) begin
      redir = no_fetch ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 49) == 0);
      tgt   = 64'h8000_0000 + 64'({$urandom_range(0, 255), 2'b00});
      if ($urandom_range(0, 7) == 0) tgt = tgt | 64'd2;
      intr  = !no_fetch && ($urandom_range(0, 79) == 0);
      step($urandom_range(0, 3) != 0, redir, tgt, intr,
           ($urandom_range(0, 1) == 0) ? INT_TIMER : INT_EXTERNAL);
    end
    chk("H_progress", 64'(n_pop > 100), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_pc.md
Name: fetch_queue_pc

Overview:
- Next-generation fetch front end: PC generator plus a parametrised prefetch queue.
- Decouples instruction-bus latency from decode stalls using a valid/ready output instead of a hold input.
- Supports redirects that arrive while a bus request is still in flight, misaligned-target exceptions and interrupt injection.
- Sits between the ibus arbiter and decode; feeds the IF/ID register.

Parameters:
PC_W, 64, PC and bus address width in bits.
DEPTH, 4, prefetch queue entries; power of two, at least 2.
PCINIT, 64'h8000_0000, fetch address after reset; truncated to PC_W.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset; asserted when 0.
ibus_req  out  ibus_req_t  fields addr, valid.
ibus_resp  in  ibus_resp_t  fields addr_ok, data_ok, data[31:0].
redirect_valid  in  1  jump or trap redirect; highest priority.
redirect_pc  in  PC_W  redirect target.
int_pending  in  1  interrupt taken, from the external interrupt judge.
int_cause  in  exception_t  interrupt cause.
out_valid  out  1  queue head is valid.
out_ready  in  1  decode accepts the head this cycle.
out_pc  out  PC_W  PC of the head entry.
out_instr  out  32  instruction word; 0 for exception entries.
out_exc_valid  out  1  head entry is an exception.
out_exc  out  exception_t  exception cause.

Behaviour:
- Reset values: ibus_req.valid=0, ibus_req.addr=PCINIT, out_valid=0, out_exc_valid=0; queue empty; fetch_pc=PCINIT; state IDLE.
- Bus protocol:
  - Once ibus_req.valid is asserted, valid and addr stay stable until a cycle with addr_ok & data_ok.
  - Valid drops in the cycle after completion.
  - At most one request is outstanding.
- FSM states: IDLE, REQ, DISCARD, HALT.
- IDLE:
  - Misaligned fetch_pc (fetch_pc[1:0]!=0) with a free slot: push an exception entry {fetch_pc, instr 0, INSTRUCTION_ADDRESS_MISALIGNED} and go to HALT. No bus request is issued.
  - Aligned fetch_pc with count + 0 < DEPTH (a slot reserved for the reply): assert the request at fetch_pc and go to REQ.
- REQ:
  - On handshake: push {fetch_pc, data}, fetch_pc += 4 (wraps mod 2^PC_W), return to IDLE.
  - A new request can therefore start at most every 2 cycles.
- DISCARD:
  - Entered when a redirect arrives in REQ without a handshake that cycle.
  - Holds the old request until its handshake, drops the returned data, then goes to IDLE.
- HALT:
  - Issues no requests.
  - Left only via a redirect.
- Redirect (any state, highest priority):
  - Flushes the queue and sets fetch_pc=redirect_pc.
  - Clears any pending interrupt entry.
  - Next state: DISCARD if a request is mid-flight without a handshake, otherwise IDLE.
  - A handshake in the same cycle is dropped.
  - A pop in the same cycle is ignored, since decode flushes too.
- Interrupt (int_pending with no redirect that cycle):
  - Flushes the queue and goes to HALT, or DISCARD-then-HALT if a request is in flight.
  - Registers an interrupt entry {pc = head pc if the queue was non-empty, else fetch_pc; exc = int_cause}.
  - From the next cycle, presents it with out_valid=1, out_exc_valid=1 until out_ready, then out_valid=0.
- Output:
  - The head is registered state, so a push becomes visible the cycle after the handshake.
  - A pop happens when out_valid & out_ready.
  - Push and pop in the same cycle are allowed, including when the queue is full.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Full queue: no new request is issued; an in-flight reply always has a reserved slot, so it is never lost.
- Reset asserted mid-request: everything returns to reset values immediately, and ibus_req.valid falls asynchronously.

Decomposition:
- Shared package (common): ibus_req_t, ibus_resp_t, exception_t, INSTRUCTION_ADDRESS_MISALIGNED, and a fetch_entry_t {pc, instr, exc_valid, exc} used by the queue.
- One natural sub-module: fetch_fifo.
  - Parametrised DEPTH and entry type.
  - Ports push, pop and flush; outputs count, head, empty and full.
  - Flush has priority over push.

Test Plan:
- Reset release, bus answers with 1-cycle latency, out_ready=1 → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; out_pc values appear in order with matching instructions.
- out_ready=0 with DEPTH=4 → exactly 4 handshakes, then ibus_req.valid stays 0; raising out_ready drains 4 entries, then fetching resumes at 0x8000_0010.
- Redirect to 0x8000_0100 while a request is pending with a 3-cycle bus delay → stale data is dropped, the next request address is 0x8000_0100, and no stale entry reaches the output.
- Redirect to 0x8000_0102 → no bus request; one entry is output with pc 0x8000_0102, out_exc=INSTRUCTION_ADDRESS_MISALIGNED, instr 0; then nothing until the next redirect.
- int_pending with 2 entries queued (head pc 0x8000_0020) → queue flushed; a single exception entry appears with pc 0x8000_0020 and out_exc=int_cause; no fetch until redirect.
- Redirect and int_pending in the same cycle → redirect wins; no interrupt entry is emitted and fetching starts at redirect_pc.
